// File: rtl/gain_loop_ctrl.sv
// Automatic gain-control sequencer for the three RF channels.
// Visits ch1..ch3 in turn: dwell, take a coherent sample of the channel's
// magnitude statistic, then step its PWM gain word toward the CPU target.
module gain_loop_ctrl #(
    parameter int DWELL     = 16384,
    parameter int STEP      = 4,
    parameter int DEADBAND  = 8,
    parameter int GAIN_MIN  = 0,
    parameter int GAIN_MAX  = 1023,
    parameter int GAIN_INIT = 512
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic [7:0] target_i,
    input  logic [2:0] hold_i,
    input  logic       load_i,
    input  logic [1:0] load_ch_i,
    input  logic [9:0] load_val_i,
    input  logic [7:0] mag1_i,
    input  logic [7:0] mag2_i,
    input  logic [7:0] mag3_i,
    output logic [9:0] gain1_o,
    output logic [9:0] gain2_o,
    output logic [9:0] gain3_o,
    output logic       busy_o,
    output logic       update_o,
    output logic [1:0] upd_ch_o
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_SAMPLE1 = 3'd2;
    localparam logic [2:0] S_SAMPLE2 = 3'd3;
    localparam logic [2:0] S_ADJUST  = 3'd4;
    localparam logic [2:0] S_NEXT    = 3'd5;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [9:0]       DB_W       = 10'(DEADBAND);
    // 12-bit signed is wide enough that gain+STEP or gain-STEP never wraps
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] MIN_S  = 12'(GAIN_MIN);
    localparam logic signed [11:0] MAX_S  = 12'(GAIN_MAX);
    localparam logic [9:0]         INIT_G = 10'(GAIN_INIT);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] dwellCnt_q, dwellCnt_d;
    logic [1:0]       chIdx_q, chIdx_d;
    logic [1:0]       retryCnt_q, retryCnt_d;
    logic [7:0]       sample1_q, sample1_d;
    logic [9:0]       gain_q [3];
    logic             update_q;
    logic [1:0]       updCh_q;

    logic [7:0]         magSel;
    logic [9:0]         gainCur;
    logic [9:0]         tgtWide, hiWide;
    logic [7:0]         bandHi, bandLo;
    logic signed [11:0] gainExt, stepped, loadWide;
    logic [9:0]         adjNew, loadClamped;
    logic               loadHitsIdx, adjFire;

    // Select the statistic and gain word of the channel currently being visited
    always_comb begin
        magSel  = mag1_i;
        gainCur = gain_q[0];
        case (chIdx_q)
            2'd1: begin
                magSel  = mag2_i;
                gainCur = gain_q[1];
            end
            2'd2: begin
                magSel  = mag3_i;
                gainCur = gain_q[2];
            end
            default: begin
                magSel  = mag1_i;
                gainCur = gain_q[0];
            end
        endcase
    end

    // Deadband window, clamped step toward target, clamped forced value, and the update decision
    always_comb begin
        tgtWide = {2'b00, target_i};
        hiWide  = tgtWide + DB_W;
        bandHi  = (hiWide > 10'd255) ? 8'hFF : 8'(hiWide);
        bandLo  = (tgtWide < DB_W) ? 8'h00 : 8'(tgtWide - DB_W);

        gainExt = signed'({2'b00, gainCur});
        stepped = gainExt;
        if (sample1_q > bandHi) begin
            stepped = gainExt - STEP_S;
            if (stepped < MIN_S) stepped = MIN_S;
        end else if (sample1_q < bandLo) begin
            stepped = gainExt + STEP_S;
            if (stepped > MAX_S) stepped = MAX_S;
        end
        adjNew = 10'(stepped);

        loadWide = signed'({2'b00, load_val_i});
        if (loadWide < MIN_S)      loadClamped = 10'(MIN_S);
        else if (loadWide > MAX_S) loadClamped = 10'(MAX_S);
        else                       loadClamped = load_val_i;

        // A forced write to the visited channel in the ADJUST cycle overrides the loop
        loadHitsIdx = load_i && (load_ch_i == chIdx_q);
        adjFire     = (state_q == S_ADJUST) && enable_i && !hold_i[chIdx_q]
                      && (adjNew != gainCur) && !loadHitsIdx;
    end

    // Sequencer next state: dwell, double-sample coherence check, adjust, advance channel
    always_comb begin
        state_d    = state_q;
        dwellCnt_d = dwellCnt_q;
        chIdx_d    = chIdx_q;
        retryCnt_d = retryCnt_q;
        sample1_d  = sample1_q;
        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d    = S_WAIT;
                    dwellCnt_d = '0;
                end
            end
            S_WAIT: begin
                dwellCnt_d = dwellCnt_q + CNT_W'(1);
                if (dwellCnt_q == DWELL_LAST) state_d = S_SAMPLE1;
            end
            S_SAMPLE1: begin
                sample1_d = magSel;
                state_d   = S_SAMPLE2;
            end
            S_SAMPLE2: begin
                if (magSel == sample1_q) begin
                    state_d = S_ADJUST;
                end else begin
                    retryCnt_d = retryCnt_q + 2'd1;
                    state_d    = (retryCnt_q == 2'd2) ? S_NEXT : S_SAMPLE1;
                end
            end
            S_ADJUST: begin
                retryCnt_d = '0;
                state_d    = S_NEXT;
            end
            S_NEXT: begin
                chIdx_d    = (chIdx_q == 2'd2) ? 2'd0 : chIdx_q + 2'd1;
                retryCnt_d = '0;
                dwellCnt_d = '0;
                state_d    = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        // Dropping enable parks the loop; the channel index survives so it resumes in place
        if (!enable_i) begin
            state_d    = S_IDLE;
            dwellCnt_d = '0;
            retryCnt_d = '0;
        end
    end

    // Sequencer registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            dwellCnt_q <= '0;
            chIdx_q    <= 2'd0;
            retryCnt_q <= 2'd0;
            sample1_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            dwellCnt_q <= dwellCnt_d;
            chIdx_q    <= chIdx_d;
            retryCnt_q <= retryCnt_d;
            sample1_q  <= sample1_d;
        end
    end

    // Gain words: forced CPU write has priority over the loop's adjustment
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < 3; i++) gain_q[i] <= INIT_G;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (load_i && (load_ch_i == 2'(i)))      gain_q[i] <= loadClamped;
                else if (adjFire && (chIdx_q == 2'(i))) gain_q[i] <= adjNew;
            end
        end
    end

    // Update pulse and sticky channel tag, aligned with the new gain value
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            update_q <= 1'b0;
            updCh_q  <= 2'd0;
        end else begin
            update_q <= adjFire;
            if (adjFire) updCh_q <= chIdx_q;
        end
    end

    assign gain1_o  = gain_q[0];
    assign gain2_o  = gain_q[1];
    assign gain3_o  = gain_q[2];
    assign busy_o   = (state_q != S_IDLE);
    assign update_o = update_q;
    assign upd_ch_o = updCh_q;

endmodule

// File: tb/tb_gain_loop_ctrl.sv
// Self-checking bench for gain_loop_ctrl: a per-visit timetable model predicts
// when each gain word changes and to what, under directed and random stimulus.
module tb_gain_loop_ctrl;

    localparam int DWELL     = 8;
    localparam int STEP      = 4;
    localparam int DEADBAND  = 8;
    localparam int GAIN_MIN  = 0;
    localparam int GAIN_MAX  = 1023;
    localparam int GAIN_INIT = 512;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] target = 8'd0;
    logic [2:0] hold = 3'b000;
    logic       load = 1'b0;
    logic [1:0] loadCh = 2'd0;
    logic [9:0] loadVal = 10'd0;
    logic [7:0] magV [3];
    logic [9:0] gain1, gain2, gain3;
    logic       busy, update;
    logic [1:0] updCh;

    int modelGain [3];
    int modelIdx;
    int modelUpdCh;
    int checks = 0;
    int passes = 0;
    int offs [5] = '{-9, -8, 0, 8, 9};

    gain_loop_ctrl #(
        .DWELL(DWELL), .STEP(STEP), .DEADBAND(DEADBAND),
        .GAIN_MIN(GAIN_MIN), .GAIN_MAX(GAIN_MAX), .GAIN_INIT(GAIN_INIT)
    ) dut (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .target_i(target),
        .hold_i(hold), .load_i(load), .load_ch_i(loadCh), .load_val_i(loadVal),
        .mag1_i(magV[0]), .mag2_i(magV[1]), .mag3_i(magV[2]),
        .gain1_o(gain1), .gain2_o(gain2), .gain3_o(gain3),
        .busy_o(busy), .update_o(update), .upd_ch_o(updCh)
    );

    // Free-running CPU clock
    always #5 clk = ~clk;

    // One comparison: count it and report a mismatch
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) passes++;
        else $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    endtask

    task automatic checkAll(input int expUpd, input int expBusy);
        checkOutput("gain1", int'(gain1), modelGain[0]);
        checkOutput("gain2", int'(gain2), modelGain[1]);
        checkOutput("gain3", int'(gain3), modelGain[2]);
        checkOutput("update", int'(update), expUpd);
        checkOutput("upd_ch", int'(updCh), modelUpdCh);
        checkOutput("busy", int'(busy), expBusy);
    endtask

    function automatic int clampGain(input int v);
        if (v < GAIN_MIN) return GAIN_MIN;
        if (v > GAIN_MAX) return GAIN_MAX;
        return v;
    endfunction

    // Gain after one evaluation, straight from the deadband/step/clamp rules
    function automatic int modelAdjust(input int g, input int m, input int t, input int held);
        int hi, lo;
        hi = t + DEADBAND;
        if (hi > 255) hi = 255;
        lo = t - DEADBAND;
        if (lo < 0) lo = 0;
        if (held != 0) return g;
        if (m > hi) return (g - STEP < GAIN_MIN) ? GAIN_MIN : g - STEP;
        if (m < lo) return (g + STEP > GAIN_MAX) ? GAIN_MAX : g + STEP;
        return g;
    endfunction

    task automatic applyStimulus();
        int v;
        target = 8'($urandom_range(0, 255));
        hold   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 2) == 0) v = int'(target) + offs[$urandom_range(0, 4)];
            else v = int'($urandom_range(0, 255));
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            magV[i] = 8'(v);
        end
    endtask

    // One channel visit from the posedge that enters WAIT; k counts posedges into the visit.
    // A coherent visit lasts DWELL+4 cycles with the new gain visible after edge DWELL+3;
    // a visit with three sample mismatches lasts DWELL+7 cycles and never adjusts.
    task automatic runVisit(input int toggle, input int loadK, input int loadC, input int loadV,
                            input int abortK, input int resetK, input int randomize);
        int ch, len, expUpd, newG;
        ch  = modelIdx;
        len = (toggle != 0) ? DWELL + 7 : DWELL + 4;
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            @(negedge clk);
            expUpd = 0;
            if (abortK >= 0 && k == abortK + 1) begin
                checkAll(0, 0);
                return;
            end
            if (toggle == 0 && k == DWELL + 3) begin
                newG = modelAdjust(modelGain[ch], int'(magV[ch]), int'(target), int'(hold[ch]));
                if (!(loadK >= 0 && k == loadK + 1 && loadC == ch) && newG != modelGain[ch]) begin
                    modelGain[ch] = newG;
                    modelUpdCh    = ch;
                    expUpd        = 1;
                end
            end
            if (loadK >= 0 && k == loadK + 1) begin
                load = 1'b0;
                if (loadC < 3) modelGain[loadC] = clampGain(loadV);
            end
            checkAll(expUpd, 1);
            if (k == 0 && randomize != 0) applyStimulus();
            if (toggle != 0) magV[ch] = (magV[ch] == 8'd10) ? 8'd200 : 8'd10;
            if (k == loadK) begin
                load    = 1'b1;
                loadCh  = 2'(loadC);
                loadVal = 10'(loadV);
            end
            if (k == abortK) enable = 1'b0;
            if (k == resetK) begin
                reset = 1'b1;
                #1;
                for (int i = 0; i < 3; i++) modelGain[i] = GAIN_INIT;
                modelIdx   = 0;
                modelUpdCh = 0;
                checkAll(0, 0);
                return;
            end
        end
        modelIdx = (modelIdx + 1) % 3;
    endtask

    task automatic runUntilCh(input int ch);
        while (modelIdx != ch) runVisit(0, -1, 0, 0, -1, -1, 0);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        for (int i = 0; i < 3; i++) begin
            magV[i]      = 8'd100;
            modelGain[i] = GAIN_INIT;
        end
        modelIdx   = 0;
        modelUpdCh = 0;

        repeat (2) @(negedge clk);
        checkAll(0, 0);
        reset = 1'b0;
        @(negedge clk);
        checkAll(0, 0);

        // Everything in band: three full rounds with no change
        target = 8'd100;
        enable = 1'b1;
        repeat (9) runVisit(0, -1, 0, 0, -1, -1, 0);

        // ch1 above band steps down by STEP
        magV[0] = 8'd200;
        repeat (3) runVisit(0, -1, 0, 0, -1, -1, 0);

        // Upper clamp on ch2
        magV[1] = 8'd0;
        runVisit(0, 1, 1, 1022, -1, -1, 0);
        repeat (4) runVisit(0, -1, 0, 0, -1, -1, 0);

        // Lower clamp on ch1
        magV[0] = 8'd255;
        runVisit(0, 1, 0, 2, -1, -1, 0);
        repeat (4) runVisit(0, -1, 0, 0, -1, -1, 0);

        // Incoherent ch3 statistic: three mismatches, then advance
        runUntilCh(2);
        runVisit(1, -1, 0, 0, -1, -1, 0);
        magV[2] = 8'd100;

        // Frozen ch1 is visited but not adjusted
        hold = 3'b001;
        runVisit(0, 1, 0, 600, -1, -1, 0);
        hold = 3'b000;

        // Forced write in the ADJUST cycle wins, then a write to channel 3 is ignored
        runUntilCh(0);
        runVisit(0, DWELL + 2, 0, 300, -1, -1, 0);
        runVisit(0, 2, 3, 5, -1, -1, 0);

        // Drop enable mid-dwell on ch2, then resume on ch2
        runUntilCh(1);
        magV[1] = 8'd255;
        runVisit(0, -1, 0, 0, 3, -1, 0);
        repeat (3) begin
            @(negedge clk);
            checkAll(0, 0);
        end
        enable = 1'b1;
        runVisit(0, -1, 0, 0, -1, -1, 0);

        // Randomized visits with random forced writes and occasional incoherent samples
        for (int n = 0; n < 40; n++) begin
            int tg, lk, lc, lv;
            tg = ($urandom_range(0, 5) == 0) ? 1 : 0;
            lk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, DWELL + 2)) : -1;
            lc = int'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       lv = 0;
                1:       lv = 1023;
                default: lv = int'($urandom_range(0, 1023));
            endcase
            runVisit(tg, lk, lc, lv, -1, -1, 1);
        end

        // Reset in the middle of ADJUST restores everything at once
        target = 8'd100;
        hold   = 3'b000;
        for (int i = 0; i < 3; i++) magV[i] = 8'd255;
        runVisit(0, -1, 0, 0, -1, DWELL + 2, 0);
        @(negedge clk);
        reset = 1'b0;
        runVisit(0, -1, 0, 0, -1, -1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
